// File: rtl/projectile_sequencer.sv
// projectile_sequencer: frame-rate controller for the single shared
// projectile sprite. It launches from the left turret muzzle, moves SPEED
// pixels per frame_tick, reverses at each playfield limit and retires after
// MAX_BOUNCES reversals, then sits in a cooldown before it accepts another
// launch.
//
// Launch handshake: fire_req is a level request and fire_ack is a one-cycle
// pulse, high in the cycle after the accepting edge. A request is accepted
// only on an edge where the state is IDLE and fire_req is high. Requests
// outside IDLE are dropped, not queued, so a held-high fire_req relaunches
// on the first IDLE cycle.
module projectile_sequencer #(
    parameter int unsigned LAUNCH_X        = 90,
    parameter int unsigned LAUNCH_Y        = 52,
    parameter int unsigned RIGHT_LIMIT     = 599,
    parameter int unsigned LEFT_LIMIT      = 10,
    parameter int unsigned SPEED           = 1,
    parameter int unsigned MAX_BOUNCES     = 8,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       fire_req,
    input  logic       abort,
    output logic       fire_ack,
    output logic       proj_valid,
    output logic       proj_dir,
    output logic [9:0] proj_x,
    output logic [9:0] proj_y,
    output logic [3:0] bounce_cnt,
    output logic       busy,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY_R    = 2'd1,
        FLY_L    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [9:0]  LAUNCH_X_V = 10'(LAUNCH_X);
    localparam logic [9:0]  LAUNCH_Y_V = 10'(LAUNCH_Y);
    localparam logic [9:0]  RIGHT_V    = 10'(RIGHT_LIMIT);
    localparam logic [9:0]  LEFT_V     = 10'(LEFT_LIMIT);
    localparam logic [9:0]  SPEED_V    = 10'(SPEED);
    localparam logic [10:0] RIGHT_W    = 11'(RIGHT_LIMIT);
    localparam logic [10:0] LEFT_W     = 11'(LEFT_LIMIT);
    localparam logic [10:0] SPEED_W    = 11'(SPEED);
    localparam logic [3:0]  MAX_B_V    = 4'(MAX_BOUNCES);
    localparam logic [7:0]  COOL_V     = 8'(COOLDOWN_FRAMES);

    state_t      state_q, state_d;
    logic        fire_ack_q, fire_ack_d;
    logic        proj_valid_q, proj_valid_d;
    logic        proj_dir_q, proj_dir_d;
    logic [9:0]  proj_x_q, proj_x_d;
    logic [9:0]  proj_y_q, proj_y_d;
    logic [3:0]  bounce_cnt_q, bounce_cnt_d;
    logic [7:0]  cool_cnt_q, cool_cnt_d;

    // Limit checks are 11 bits wide so the sums can never wrap.
    logic [10:0] x_ext;
    logic        hit_right;
    logic        hit_left;
    logic [3:0]  bounce_inc;
    logic        retire;

    assign x_ext      = {1'b0, proj_x_q};
    assign hit_right  = (x_ext + SPEED_W) >= RIGHT_W;
    assign hit_left   = x_ext <= (LEFT_W + SPEED_W);
    assign bounce_inc = bounce_cnt_q + 4'd1;
    assign retire     = (bounce_inc == MAX_B_V);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            fire_ack_q   <= 1'b0;
            proj_valid_q <= 1'b0;
            proj_dir_q   <= 1'b0;
            proj_x_q     <= LAUNCH_X_V;
            proj_y_q     <= LAUNCH_Y_V;
            bounce_cnt_q <= 4'd0;
            cool_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            fire_ack_q   <= fire_ack_d;
            proj_valid_q <= proj_valid_d;
            proj_dir_q   <= proj_dir_d;
            proj_x_q     <= proj_x_d;
            proj_y_q     <= proj_y_d;
            bounce_cnt_q <= bounce_cnt_d;
            cool_cnt_q   <= cool_cnt_d;
        end
    end

    // Next-state logic; abort takes priority over a coincident frame_tick.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fire_req) state_d = FLY_R;
            end
            FLY_R: begin
                if (abort) begin
                    state_d = COOLDOWN;
                end else if (frame_tick && hit_right) begin
                    state_d = retire ? COOLDOWN : FLY_L;
                end
            end
            FLY_L: begin
                if (abort) begin
                    state_d = COOLDOWN;
                end else if (frame_tick && hit_left) begin
                    state_d = retire ? COOLDOWN : FLY_R;
                end
            end
            COOLDOWN: begin
                if (frame_tick && (cool_cnt_q == 8'd0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; everything holds unless an event fires.
    always_comb begin
        fire_ack_d   = 1'b0;
        proj_valid_d = proj_valid_q;
        proj_dir_d   = proj_dir_q;
        proj_x_d     = proj_x_q;
        proj_y_d     = proj_y_q;
        bounce_cnt_d = bounce_cnt_q;
        cool_cnt_d   = cool_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (fire_req) begin
                    fire_ack_d   = 1'b1;
                    proj_valid_d = 1'b1;
                    proj_dir_d   = 1'b0;
                    proj_x_d     = LAUNCH_X_V;
                    proj_y_d     = LAUNCH_Y_V;
                    bounce_cnt_d = 4'd0;
                end
            end
            FLY_R: begin
                if (abort) begin
                    proj_valid_d = 1'b0;
                    cool_cnt_d   = COOL_V;
                end else if (frame_tick) begin
                    if (hit_right) begin
                        proj_x_d     = RIGHT_V;
                        proj_dir_d   = 1'b1;
                        bounce_cnt_d = bounce_inc;
                        if (retire) begin
                            proj_valid_d = 1'b0;
                            cool_cnt_d   = COOL_V;
                        end
                    end else begin
                        proj_x_d = proj_x_q + SPEED_V;
                    end
                end
            end
            FLY_L: begin
                if (abort) begin
                    proj_valid_d = 1'b0;
                    cool_cnt_d   = COOL_V;
                end else if (frame_tick) begin
                    if (hit_left) begin
                        proj_x_d     = LEFT_V;
                        proj_dir_d   = 1'b0;
                        bounce_cnt_d = bounce_inc;
                        if (retire) begin
                            proj_valid_d = 1'b0;
                            cool_cnt_d   = COOL_V;
                        end
                    end else begin
                        proj_x_d = proj_x_q - SPEED_V;
                    end
                end
            end
            COOLDOWN: begin
                if (frame_tick && (cool_cnt_q != 8'd0)) cool_cnt_d = cool_cnt_q - 8'd1;
            end
            default: ;
        endcase
    end

    assign fire_ack   = fire_ack_q;
    assign proj_valid = proj_valid_q;
    assign proj_dir   = proj_dir_q;
    assign proj_x     = proj_x_q;
    assign proj_y     = proj_y_q;
    assign bounce_cnt = bounce_cnt_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_projectile_sequencer.sv
// Directed bench for projectile_sequencer, built with MAX_BOUNCES = 2 and
// COOLDOWN_FRAMES = 3 so a full flight ends in retirement.
module tb_projectile_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FLYR = 2'd1;
    localparam logic [1:0] S_FLYL = 2'd2;
    localparam logic [1:0] S_COOL = 2'd3;

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       fire_req = 1'b0;
    logic       abort = 1'b0;
    logic       fire_ack;
    logic       proj_valid;
    logic       proj_dir;
    logic [9:0] proj_x;
    logic [9:0] proj_y;
    logic [3:0] bounce_cnt;
    logic       busy;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt = 0;

    projectile_sequencer #(
        .MAX_BOUNCES    (2),
        .COOLDOWN_FRAMES(3)
    ) dut (
        .vga_clk   (vga_clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .fire_req  (fire_req),
        .abort     (abort),
        .fire_ack  (fire_ack),
        .proj_valid(proj_valid),
        .proj_dir  (proj_dir),
        .proj_x    (proj_x),
        .proj_y    (proj_y),
        .bounce_cnt(bounce_cnt),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // 100 MHz clock
    always #5 vga_clk = ~vga_clk;

    // One clock edge; outputs are sampled 1 ns after it and acks are tallied.
    task automatic step();
        @(posedge vga_clk);
        #1;
        if (fire_ack === 1'b1) ack_cnt++;
    endtask

    // n frame ticks, each a one-cycle strobe followed by one quiet cycle.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(proj_valid), 32'd0);
        check({tag, "_dir"},   32'(proj_dir),   32'd0);
        check({tag, "_x"},     32'(proj_x),     32'd90);
        check({tag, "_y"},     32'(proj_y),     32'd52);
        check({tag, "_bnc"},   32'(bounce_cnt), 32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_ack"},   32'(fire_ack),   32'd0);
        check({tag, "_state"}, 32'(dbg_state),  32'(S_IDLE));
    endtask

    initial begin
        // Reset for two cycles, then release.
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        check_reset_vals("rst");

        // Launch with a coincident frame_tick: no motion on the accepting edge.
        fire_req   = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check("launch_ack",   32'(fire_ack),   32'd1);
        check("launch_valid", 32'(proj_valid), 32'd1);
        check("launch_x",     32'(proj_x),     32'd90);
        check("launch_state", 32'(dbg_state),  32'(S_FLYR));
        step();
        check("ack_one_cycle", 32'(fire_ack), 32'd0);
        ack_cnt = 0;

        // Rightward flight with fire_req still held.
        tick_n(508);
        check("right_598_x",   32'(proj_x),   32'd598);
        check("right_598_dir", 32'(proj_dir), 32'd0);
        tick_n(1);
        check("bounce1_x",     32'(proj_x),     32'd599);
        check("bounce1_dir",   32'(proj_dir),   32'd1);
        check("bounce1_cnt",   32'(bounce_cnt), 32'd1);
        check("bounce1_state", 32'(dbg_state),  32'(S_FLYL));

        // Leftward flight; second reversal retires the projectile.
        tick_n(588);
        check("left_11_x", 32'(proj_x), 32'd11);
        fire_req = 1'b0;
        tick_n(1);
        check("bounce2_x",     32'(proj_x),     32'd10);
        check("bounce2_dir",   32'(proj_dir),   32'd0);
        check("bounce2_cnt",   32'(bounce_cnt), 32'd2);
        check("retire_valid",  32'(proj_valid), 32'd0);
        check("retire_busy",   32'(busy),       32'd1);
        check("retire_state",  32'(dbg_state),  32'(S_COOL));
        check("no_second_ack", 32'(ack_cnt),    32'd0);

        // Cooldown lasts COOLDOWN_FRAMES + 1 ticks.
        tick_n(3);
        check("cool_3_busy", 32'(busy), 32'd1);
        tick_n(1);
        check("cool_4_busy",  32'(busy),       32'd0);
        check("cool_4_state", 32'(dbg_state),  32'(S_IDLE));
        check("idle_hold_x",  32'(proj_x),     32'd10);
        check("idle_hold_bc", 32'(bounce_cnt), 32'd2);

        // abort in IDLE is ignored.
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle_state", 32'(dbg_state), 32'(S_IDLE));

        // Relaunch after cooldown.
        fire_req = 1'b1;
        step();
        fire_req = 1'b0;
        check("relaunch_ack", 32'(fire_ack),   32'd1);
        check("relaunch_x",   32'(proj_x),     32'd90);
        check("relaunch_bc",  32'(bounce_cnt), 32'd0);
        check("relaunch_dir", 32'(proj_dir),   32'd0);

        // Abort wins over a coincident tick at x = 200.
        tick_n(110);
        check("pre_abort_x", 32'(proj_x), 32'd200);
        abort      = 1'b1;
        frame_tick = 1'b1;
        step();
        abort      = 1'b0;
        frame_tick = 1'b0;
        check("abort_x",     32'(proj_x),     32'd200);
        check("abort_valid", 32'(proj_valid), 32'd0);
        check("abort_state", 32'(dbg_state),  32'(S_COOL));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_cool_state", 32'(dbg_state), 32'(S_COOL));
        tick_n(4);
        check("abort_cool_done", 32'(dbg_state), 32'(S_IDLE));

        // Reset mid-flight in FLY_L at x = 300.
        fire_req = 1'b1;
        step();
        fire_req = 1'b0;
        tick_n(509);
        tick_n(299);
        check("mid_x",     32'(proj_x),    32'd300);
        check("mid_state", 32'(dbg_state), 32'(S_FLYL));
        Reset      = 1'b1;
        frame_tick = 1'b1;
        step();
        Reset      = 1'b0;
        frame_tick = 1'b0;
        check_reset_vals("midrst");
        ack_cnt = 0;
        step();
        step();
        step();
        check("midrst_no_ack", 32'(ack_cnt),   32'd0);
        check("midrst_idle",   32'(dbg_state), 32'(S_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
